// File: rtl/dbg_bus_pkg.sv
// Shared command/response codes and FSM state type for the debug bus master.
package dbg_bus_pkg;

   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] RSP_ACK = 8'h4B;
   localparam logic [7:0] RSP_ERR = 8'h45;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_DLO  = 3'd2,
      ST_DHI  = 3'd3,
      ST_BUS  = 3'd4,
      ST_RSP0 = 3'd5,
      ST_RSP1 = 3'd6
   } state_t;

endpackage

// File: rtl/dbg_bus_master.sv
// Byte-stream command master for the debug register bus; one strobe per frame, strobe rises the cycle after the last frame byte.
// rx stalls outside the parse states; tx_data is held until the sink accepts it; strobe aborts after TIMEOUT+1 cycles.
module dbg_bus_master
   import dbg_bus_pkg::*;
#(
   parameter int TIMEOUT = 1023,
   parameter int TO_W    = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  dbg_a,
   output logic [15:0] dbg_di,
   output logic        dbg_we,
   output logic        dbg_rd,
   input  logic [15:0] dbg_do,
   input  logic        dbg_ready
);

   state_t          state;
   logic            is_rd;
   logic            err;
   logic [7:0]      rd_hi;
   logic [TO_W-1:0] to_cnt;
   logic            rx_hs;
   logic            tx_hs;

   assign rx_ready = (state == ST_IDLE) || (state == ST_ADDR) ||
                     (state == ST_DLO)  || (state == ST_DHI);
   assign rx_hs    = rx_valid & rx_ready;
   assign tx_hs    = tx_valid & tx_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         is_rd    <= 1'b0;
         err      <= 1'b0;
         rd_hi    <= 8'h00;
         to_cnt   <= '0;
         dbg_a    <= 8'h00;
         dbg_di   <= 16'h0000;
         dbg_we   <= 1'b0;
         dbg_rd   <= 1'b0;
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // Unknown bytes are swallowed silently so the host can resync.
               if (rx_hs && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
                  is_rd <= (rx_data == CMD_RD);
                  err   <= 1'b0;
                  state <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (rx_hs) begin
                  dbg_a <= rx_data;
                  if (is_rd) begin
                     dbg_rd <= 1'b1;
                     to_cnt <= '0;
                     state  <= ST_BUS;
                  end else begin
                     state <= ST_DLO;
                  end
               end
            end
            ST_DLO: begin
               if (rx_hs) begin
                  dbg_di[7:0] <= rx_data;
                  state       <= ST_DHI;
               end
            end
            ST_DHI: begin
               if (rx_hs) begin
                  dbg_di[15:8] <= rx_data;
                  dbg_we       <= 1'b1;
                  to_cnt       <= '0;
                  state        <= ST_BUS;
               end
            end
            ST_BUS: begin
               // Ready wins over timeout when both land in the same cycle.
               if (dbg_ready) begin
                  dbg_we   <= 1'b0;
                  dbg_rd   <= 1'b0;
                  tx_valid <= 1'b1;
                  if (is_rd) begin
                     tx_data <= dbg_do[7:0];
                     rd_hi   <= dbg_do[15:8];
                  end else begin
                     tx_data <= RSP_ACK;
                  end
                  state <= ST_RSP0;
               end else if (to_cnt == TO_W'(TIMEOUT)) begin
                  dbg_we   <= 1'b0;
                  dbg_rd   <= 1'b0;
                  err      <= 1'b1;
                  tx_valid <= 1'b1;
                  tx_data  <= RSP_ERR;
                  state    <= ST_RSP0;
               end else if (to_cnt != '1) begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            ST_RSP0: begin
               if (tx_hs) begin
                  if (is_rd && !err) begin
                     tx_data <= rd_hi;
                     state   <= ST_RSP1;
                  end else begin
                     tx_valid <= 1'b0;
                     state    <= ST_IDLE;
                  end
               end
            end
            ST_RSP1: begin
               if (tx_hs) begin
                  tx_valid <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/dbg_bus_master.md
# dbg_bus_master

Byte-stream command master that drives the debug register interface (`dbg_a`, `dbg_di`, `dbg_do`, `dbg_we`, `dbg_rd`, `dbg_ready`) from the initiator side. It sits between the host link (UART/SPI byte receiver and transmitter) and the debug register block. It parses read/write command frames, issues exactly one bus strobe per frame, waits for `dbg_ready` with a timeout, and returns an ack, read data or an error byte on the transmit stream.

## Interface
- `TIMEOUT`, default 1023: maximum number of cycles a strobe stays asserted without `dbg_ready` before the access is aborted.
- `TO_W`, default 10: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `rx_data`  in  8  incoming command byte
- `rx_valid`  in  1  `rx_data` is valid
- `rx_ready`  out  1  block accepts a byte; transfer occurs when `rx_valid & rx_ready`
- `tx_data`  out  8  response byte
- `tx_valid`  out  1  `tx_data` is valid
- `tx_ready`  in  1  sink accepts the byte; transfer occurs when `tx_valid & tx_ready`
- `dbg_a`  out  8  register address, registered
- `dbg_di`  out  16  write data, registered
- `dbg_we`  out  1  write strobe, registered
- `dbg_rd`  out  1  read strobe, registered
- `dbg_do`  in  16  read data; valid in the cycle where `dbg_rd & dbg_ready`
- `dbg_ready`  in  1  access complete; may be combinational, including in the same cycle the strobe rises

## Operation
- Frame formats:
  - Write: 0x57, addr, data[7:0], data[15:8].
  - Read: 0x52, addr.
- Any other byte received in IDLE is consumed and discarded, with no response.
- States: IDLE, ADDR, DLO, DHI, BUS, RSP0, RSP1.
  - IDLE: on 0x57 or 0x52 → ADDR, and latch the op.
  - ADDR: latch the byte into `dbg_a`. Write → DLO; read → BUS.
  - DLO: latch `dbg_di[7:0]`, then → DHI.
  - DHI: latch `dbg_di[15:8]`, then → BUS.
  - BUS: the strobe (`dbg_we` or `dbg_rd`) is high.
    - If `dbg_ready` = 1: drop the strobe on the next edge, capture `dbg_do` on a read, → RSP0.
    - Else if the timeout count reaches TIMEOUT: drop the strobe, set the error flag, → RSP0.
  - RSP0: present the byte:
    - write OK: 0x4B
    - read OK: data[7:0]
    - error: 0x45
    - On handshake: a read without error → RSP1; otherwise → IDLE.
  - RSP1: present data[15:8]; on handshake → IDLE.
- `rx_ready` = 1 in IDLE, ADDR, DLO and DHI; 0 otherwise.
- `dbg_a` and `dbg_di` stay stable for the whole strobe.
- `dbg_we` and `dbg_rd` are never high together.
- The strobe is high for exactly the cycles from entering BUS through the first cycle with `dbg_ready` = 1. The responder therefore sees `ready` with the strobe for exactly one cycle, so auto-increment registers advance once.
- The timeout counter clears on entry to BUS and increments each BUS cycle without ready. The counter saturates and does not wrap.
- `tx_data` is held stable while `tx_valid & !tx_ready`.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-strobe): state IDLE; `dbg_a` = 0, `dbg_di` = 0, `dbg_we` = 0, `dbg_rd` = 0, `tx_valid` = 0, `tx_data` = 0, `rx_ready` = 1. A partial frame is discarded.
- The strobe rises the cycle after the final frame byte handshake.
- With zero-wait `dbg_ready`, the strobe is high for 1 cycle. `tx_valid` rises the cycle after the ready cycle.
- A wait of N cycles (N ≥ 0) before ready gives a strobe width of N+1.
- On timeout, the strobe is high for TIMEOUT+1 cycles, then `tx_valid` rises with 0x45 on the next cycle.
- With back-to-back frames and an always-ready responder and sink, a write costs 4 rx + 1 bus + 1 tx cycles.

## Structure
- Shared package `dbg_bus_pkg`:
  - Command codes CMD_WR = 0x57, CMD_RD = 0x52.
  - Response codes RSP_ACK = 0x4B, RSP_ERR = 0x45.
  - State enum type.
- Single module, no sub-module. The timeout counter is inline.

## Test plan
- Write 0x57,0x1B,0x34,0x12 with `dbg_ready` tied high → `dbg_we` high for 1 cycle with `dbg_a` = 0x1B and `dbg_di` = 0x1234; tx 0x4B.
- Read 0x52,0x20 with `dbg_ready` after 5 wait cycles and `dbg_do` = 0xBEEF → `dbg_rd` high for 6 cycles; tx 0xEF then 0xBE.
- Read 0x52,0x05 with `dbg_ready` never asserted and TIMEOUT = 15 → `dbg_rd` high for 16 cycles, then drops; tx 0x45; next frame works normally.
- Bytes 0x00,0xFF, then a valid read → junk produces no tx and no strobe; the read completes correctly.
- Read response with `tx_ready` low for 10 cycles → `tx_valid` held and `tx_data` = low byte stable; `rx_ready` = 0 throughout.
- Assert `rst_n` = 0 mid-BUS → `dbg_rd` and `dbg_we` go low without a clock edge; after release, `rx_ready` = 1 and no response is emitted.
